// File: rtl/uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// UART RX frame sequencer: edge/bit counters and the frame FSM that times the
// oversampler, deserializer and the start/parity/stop checkers.
// Optional build macro: UART_RX_FRAME_ERR_CNT_EN adds the frame_err_cnt output,
// a saturating count of frames that ended with a parity or stop error.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 par_en,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic                 start_glitch,
  input  logic                 par_err,
  input  logic                 stop_err,
  output logic                 dat_samp_en,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 deser_en,
  output logic                 start_chk_en,
  output logic                 par_chk_en,
  output logic                 stop_chk_en,
  output logic                 data_valid,
  output logic                 par_err_flag,
  output logic                 stop_err_flag
`ifdef UART_RX_FRAME_ERR_CNT_EN
  ,
  output logic [7:0]           frame_err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PRESC_W-1:0]     edge_nxt;
  logic [BIT_CNT_W-1:0]   bit_nxt;
  logic [PRESC_W-1:0]     chk;
  logic [PRESC_W-1:0]     chk_rd;
  logic [PRESC_W-1:0]     p_last;
  logic                   at_last;
  logic                   at_rd;
  logic                   start_det;
  logic                   stop_exit;
  logic                   par_en_lat;

  // CHK is the mid-bit edge where the majority sample is ready; results come back one edge later.
  assign chk       = (prescale >> 1) + PRESC_W'(2);
  assign chk_rd    = chk + PRESC_W'(1);
  assign p_last    = prescale - PRESC_W'(1);
  assign at_last   = (edge_cnt == p_last);
  assign at_rd     = (edge_cnt == chk_rd);
  assign start_det = (state == IDLE) && !rx_in;
  assign stop_exit = (state == STOP) && at_rd;

  assign dat_samp_en = (state != IDLE);

  // Next state plus next edge/bit counter values; pulses are registered from these.
  always_comb begin
    state_nxt = state;
    edge_nxt  = '0;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        if (!rx_in) state_nxt = START;
      end
      START: begin
        if (at_rd && start_glitch) state_nxt = IDLE;
        else if (at_last)          state_nxt = DATA;
      end
      DATA: begin
        if (at_last) begin
          if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))
            state_nxt = par_en_lat ? PARITY : STOP;
          else
            bit_nxt = bit_cnt + BIT_CNT_W'(1);
        end
      end
      PARITY: begin
        if (at_last) state_nxt = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so half a bit remains to catch the next start edge.
        if (at_rd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state != DATA) && (state_nxt == DATA)) bit_nxt = '0;
    if ((state != IDLE) && (state_nxt != IDLE))
      edge_nxt = at_last ? '0 : edge_cnt + PRESC_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

  // Mid-bit enables, timed so each is high while edge_cnt shows CHK in its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deser_en     <= 1'b0;
      start_chk_en <= 1'b0;
      par_chk_en   <= 1'b0;
      stop_chk_en  <= 1'b0;
    end else begin
      deser_en     <= (state_nxt == DATA)   && (edge_nxt == chk);
      start_chk_en <= (state_nxt == START)  && (edge_nxt == chk);
      par_chk_en   <= (state_nxt == PARITY) && (edge_nxt == chk);
      stop_chk_en  <= (state_nxt == STOP)   && (edge_nxt == chk);
    end
  end

  // Frame qualification: latched parity mode, sticky error flags and data_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_lat    <= 1'b0;
      par_err_flag  <= 1'b0;
      stop_err_flag <= 1'b0;
      data_valid    <= 1'b0;
    end else begin
      if (start_det) begin
        par_en_lat    <= par_en;
        par_err_flag  <= 1'b0;
        stop_err_flag <= 1'b0;
      end
      if ((state == PARITY) && at_rd && par_err) par_err_flag <= 1'b1;
      if (stop_exit && stop_err) stop_err_flag <= 1'b1;
      // stop_err is used raw because its flag only lands in this same cycle.
      data_valid <= stop_exit && !stop_err && !par_err_flag;
    end
  end

`ifdef UART_RX_FRAME_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Count frames that finished with a parity or stop error; glitch aborts never reach STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_cnt <= 8'd0;
    end else if (stop_exit && (par_err_flag || stop_err)) begin
      frame_err_cnt <= sat_inc(frame_err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for uart_rx_frame_ctrl: acts as the RX checkers and compares every busy
// cycle against frame timing computed arithmetically from prescale and parity mode.
module tb_uart_rx_frame_ctrl;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       start_glitch;
  logic       par_err;
  logic       stop_err;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en;
  logic       start_chk_en;
  logic       par_chk_en;
  logic       stop_chk_en;
  logic       data_valid;
  logic       par_err_flag;
  logic       stop_err_flag;
`ifdef UART_RX_FRAME_ERR_CNT_EN
  logic [7:0] frame_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ref_err_cnt = 0;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .start_glitch(start_glitch), .par_err(par_err), .stop_err(stop_err),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .deser_en(deser_en), .start_chk_en(start_chk_en), .par_chk_en(par_chk_en),
    .stop_chk_en(stop_chk_en), .data_valid(data_valid),
    .par_err_flag(par_err_flag), .stop_err_flag(stop_err_flag)
`ifdef UART_RX_FRAME_ERR_CNT_EN
    , .frame_err_cnt(frame_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({dat_samp_en, edge_cnt, bit_cnt, deser_en, start_chk_en, par_chk_en,
                 stop_chk_en, data_valid, par_err_flag, stop_err_flag});
  endfunction

  // Idle gap: no busy cycles and no data_valid expected.
  task automatic idle_cycles(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dat_samp_en || data_valid) bad++;
    end
    if (n > 0) check_val("idle_quiet", bad, 0);
  endtask

  // One frame starting at the current negedge. The bench plays the checkers,
  // returning each result one clock after its enable was seen.
  task automatic run_frame(input int p, input bit pe, input bit glitch, input int low_clks,
                           input bit pbad, input bit sbad);
    int chk, busy_exp, i, stop_base, n_des;
    int bad_edge, bad_bit, bad_des, bad_sck, bad_pck, bad_stk, bad_dv, bad_clr;
    bit done, ps, pp, pt, in_data, exp_dv, exp_pf, exp_sf;
    chk       = p / 2 + 2;
    stop_base = (1 + DW + (pe ? 1 : 0)) * p;
    busy_exp  = glitch ? chk + 2 : stop_base + chk + 2;
    exp_pf    = !glitch && pe && pbad;
    exp_sf    = !glitch && sbad;
    exp_dv    = !glitch && !exp_pf && !exp_sf;
    {bad_edge, bad_bit, bad_des, bad_sck, bad_pck, bad_stk, bad_dv, bad_clr, n_des} = '0;
    {ps, pp, pt, done} = '0;
    prescale = 6'(p);
    par_en   = pe;
    rx_in    = 1'b0;
    i = 0;
    while (!done && i < 2000) begin
      @(negedge clk);
      if (dat_samp_en) begin
        in_data = !glitch && (i >= p) && (i < (1 + DW) * p);
        if (int'(edge_cnt) != i % p) bad_edge++;
        if (in_data && int'(bit_cnt) != i / p - 1) bad_bit++;
        if (deser_en != (in_data && (i % p == chk))) bad_des++;
        if (start_chk_en != (i == chk)) bad_sck++;
        if (par_chk_en != (!glitch && pe && (i == DW * p + p + chk))) bad_pck++;
        if (stop_chk_en != (!glitch && (i == stop_base + chk))) bad_stk++;
        if (data_valid) bad_dv++;
        if (i == 0 && (par_err_flag || stop_err_flag)) bad_clr++;
        if (deser_en) n_des++;
        i++;
      end else begin
        done = 1'b1;
      end
      start_glitch = ps & glitch;
      par_err      = pp & pbad;
      stop_err     = pt & sbad;
      ps = start_chk_en;
      pp = par_chk_en;
      pt = stop_chk_en;
      if (done || i >= low_clks) rx_in = 1'b1;
      par_en = 1'($urandom_range(0, 1));
    end
    check_val("busy_len", i, busy_exp);
    check_val("edge_seq", bad_edge, 0);
    check_val("bit_seq", bad_bit, 0);
    check_val("deser_pos", bad_des, 0);
    check_val("deser_cnt", n_des, glitch ? 0 : DW);
    check_val("start_chk_pos", bad_sck, 0);
    check_val("par_chk_pos", bad_pck, 0);
    check_val("stop_chk_pos", bad_stk, 0);
    check_val("dv_early", bad_dv, 0);
    check_val("flags_cleared", bad_clr, 0);
    check_val("data_valid", int'(data_valid), int'(exp_dv));
    check_val("par_err_flag", int'(par_err_flag), int'(exp_pf));
    check_val("stop_err_flag", int'(stop_err_flag), int'(exp_sf));
    check_val("edge_idle", int'(edge_cnt), 0);
    if (exp_pf || exp_sf) ref_err_cnt = (ref_err_cnt < 255) ? ref_err_cnt + 1 : 255;
`ifdef UART_RX_FRAME_ERR_CNT_EN
    check_val("frame_err_cnt", int'(frame_err_cnt), ref_err_cnt);
`endif
  endtask

  int plist[3] = '{8, 16, 32};

  initial begin
    rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
    start_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", out_vec(), 0);
`ifdef UART_RX_FRAME_ERR_CNT_EN
    check_val("reset_err_cnt", int'(frame_err_cnt), 0);
`endif
    rst = 1'b1;
    idle_cycles(3);

    run_frame(8, 1'b0, 1'b0, 1, 1'b0, 1'b0);   // clean frame, no parity
    idle_cycles(2);
    run_frame(8, 1'b1, 1'b0, 1, 1'b1, 1'b0);   // parity error
    idle_cycles(2);
    run_frame(16, 1'b0, 1'b0, 1, 1'b0, 1'b1);  // stop error
    idle_cycles(2);
    run_frame(8, 1'b0, 1'b1, 3, 1'b0, 1'b0);   // start glitch abort
    idle_cycles(2);
    run_frame(32, 1'b0, 1'b0, 1, 1'b0, 1'b0);  // back-to-back pair
    run_frame(32, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    idle_cycles(2);

    // Asynchronous reset in the middle of data bit 3.
    prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (34) @(negedge clk);
    check_val("pre_reset_busy", int'(dat_samp_en), 1);
    #1 rst = 1'b0;
    #1 check_val("mid_reset_outputs", out_vec(), 0);
    ref_err_cnt = 0;
`ifdef UART_RX_FRAME_ERR_CNT_EN
    check_val("mid_reset_err_cnt", int'(frame_err_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);
    run_frame(8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomized frames, some chained back-to-back.
    for (int n = 0; n < 30; n++) begin
      bit g;
      g = ($urandom_range(0, 5) == 0);
      run_frame(plist[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), g,
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0));
      idle_cycles(int'($urandom_range(0, 3)));
    end

`ifdef UART_RX_FRAME_ERR_CNT_EN
    for (int n = 0; n < 256; n++) run_frame(8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    check_val("err_cnt_saturated", int'(frame_err_cnt), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
